fir_wavelet_core: RTL and testbench

// - 9-tap signed FIR applying the fixed symmetric wavelet kernel to a window of

---
 rtl/wavelet_pkg.sv | 19 +
 rtl/fir_sat_trunc.sv | 29 ++
 rtl/fir_wavelet_core.sv | 108 ++++++++++
 tb/tb_fir_wavelet_core.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wavelet_pkg.sv
// Shared constants and types for the wavelet FIR channels.
package wavelet_pkg;

  localparam int BITS_PER_ELEM  = 8;
  localparam int FIR_NUM_ELEM   = 9;
  localparam int SUM_TRUNCATION = 8;
  localparam int FIR_MAX_BITS   = 16;

  // Symmetric wavelet kernel, coeff[k] = WAVELET_KERNEL[8k+:8]:
  // [-10, -36, -59, 28, 124, 28, -59, -36, -10], sum = -30.
  localparam logic [FIR_NUM_ELEM*BITS_PER_ELEM-1:0] WAVELET_KERNEL = 72'hf6dcc51c7c1cc5dcf6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_sat_trunc.sv
// Arithmetic right shift of the accumulator to the output binary point,
// followed by saturation to a signed OUT_W-bit result.
module fir_sat_trunc #(
  parameter int ACC_W = 20,
  parameter int SHIFT = 8,
  parameter int OUT_W = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] sat
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2**(OUT_W-1)));

  logic signed [ACC_W-1:0] shifted;

  // Floor-shift (toward -inf), then clamp into the signed output range.
  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted > MAX_V) begin
      sat = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      sat = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fir_wavelet_core.sv
// Sequential 9-tap signed FIR over a captured window of rolling-average
// samples. One multiply per cycle with a registered product, so a result
// appears NUM_ELEM+2 edges after the start pulse.
//
// Handshake: i_start_calc is a one-cycle request that is only honoured in
// IDLE (no back-pressure, no queueing); o_valid is a one-cycle strobe that
// marks the edge on which o_wavelet took its new value, and o_wavelet holds
// until the next strobe.
module fir_wavelet_core
  import wavelet_pkg::*;
#(
  parameter int                                   BITS_PER_ELEM_P = BITS_PER_ELEM,
  parameter int                                   NUM_ELEM        = FIR_NUM_ELEM,
  parameter logic [NUM_ELEM*BITS_PER_ELEM_P-1:0]  FILTER_VAL      = WAVELET_KERNEL,
  parameter int                                   MAX_BITS        = FIR_MAX_BITS,
  parameter int                                   SUM_TRUNC       = SUM_TRUNCATION
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_start_calc,
  input  logic [NUM_ELEM*BITS_PER_ELEM_P-1:0] taps,
  output logic [SUM_TRUNC-1:0]                o_wavelet,
  output logic                                o_valid,
  output logic [1:0]                          dbg_state
);

  localparam int B      = BITS_PER_ELEM_P;
  localparam int PROD_W = 2*B;
  // Worst-case sum of NUM_ELEM products fits without overflow.
  localparam int ACC_W  = PROD_W + $clog2(NUM_ELEM);
  // Index runs one past the last tap to drain the product register.
  localparam int IDX_W  = $clog2(NUM_ELEM+1);

  state_t                       state;
  logic [NUM_ELEM*B-1:0]        tap_copy;
  logic [IDX_W-1:0]             idx;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc;
  logic signed [B-1:0]          cur_tap;
  logic signed [B-1:0]          cur_coeff;
  logic [SUM_TRUNC-1:0]         sat_val;

  assign dbg_state = state;

  // Select the tap/coefficient pair addressed by idx (zero once past the end).
  always_comb begin
    cur_tap   = '0;
    cur_coeff = '0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_tap   = tap_copy[k*B +: B];
        cur_coeff = FILTER_VAL[k*B +: B];
      end
    end
  end

  fir_sat_trunc #(
    .ACC_W (ACC_W),
    .SHIFT (MAX_BITS - SUM_TRUNC),
    .OUT_W (SUM_TRUNC)
  ) u_sat (
    .acc (acc),
    .sat (sat_val)
  );

  // Control FSM with the tap capture, multiply pipeline and accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tap_copy  <= '0;
      idx       <= '0;
      prod      <= '0;
      acc       <= '0;
      o_wavelet <= '0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start_calc) begin
            tap_copy <= taps;
            idx      <= '0;
            prod     <= '0;
            acc      <= '0;
            state    <= MAC;
          end
        end
        MAC: begin
          // prod holds the previous tap's product (zero on the first cycle).
          acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
          if (idx == IDX_W'(NUM_ELEM)) begin
            state <= DONE;
          end else begin
            prod <= cur_tap * cur_coeff;
            idx  <= idx + 1'b1;
          end
        end
        DONE: begin
          o_wavelet <= sat_val;
          o_valid   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_wavelet_core.sv
// Directed bench for fir_wavelet_core: reset, impulse, kernel sum,
// saturation both ways, busy/ignored start, mid-MAC tap change, abort by
// reset and back-to-back calculations.
module tb_fir_wavelet_core;

  logic        clk;
  logic        rst;
  logic        i_start_calc;
  logic [71:0] taps;
  logic [7:0]  o_wavelet;
  logic        o_valid;
  logic [1:0]  dbg_state;

  int          assert_cnt;
  int          fail_cnt;
  int          valid_cnt;
  int          valid_base;
  logic [7:0]  exp_q[$];

  fir_wavelet_core dut (
    .clk          (clk),
    .rst          (rst),
    .i_start_calc (i_start_calc),
    .taps         (taps),
    .o_wavelet    (o_wavelet),
    .o_valid      (o_valid),
    .dbg_state    (dbg_state)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  // Count o_valid strobes away from the active edge.
  always @(negedge clk) begin
    if (o_valid === 1'b1) valid_cnt++;
  end

  // Tap window helpers (tap k = bits [8k+:8]).
  function automatic logic [71:0] fill(input logic [7:0] v);
    return {9{v}};
  endfunction

  function automatic logic [71:0] impulse(input logic [7:0] v);
    logic [71:0] t;
    t = '0;
    t[4*8 +: 8] = v;
    return t;
  endfunction

  // pos goes where the coefficient is positive (k = 3..5), neg elsewhere.
  function automatic logic [71:0] sign_pattern(input logic [7:0] pos, input logic [7:0] neg);
    logic [71:0] t;
    for (int k = 0; k < 9; k++) begin
      t[k*8 +: 8] = (k >= 3 && k <= 5) ? pos : neg;
    end
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the start pulse is captured on the next posedge (edge 0).
  task automatic pulse_start(input logic [71:0] v);
    taps         = v;
    i_start_calc = 1'b1;
    @(negedge clk);
    i_start_calc = 1'b0;
  endtask

  // Wait (bounded) for o_valid, counting edges since the start edge; check
  // latency, value from the expected queue and the one-cycle pulse width.
  task automatic wait_result(input string tag, input int elapsed);
    int         n;
    logic [7:0] exp;
    n   = elapsed;
    exp = 8'h00;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    while (o_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 11);
    check({tag, "_value"}, {24'h0, o_wavelet}, {24'h0, exp});
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'h0, o_valid}, 32'h0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    assert_cnt   = 0;
    fail_cnt     = 0;
    valid_cnt    = 0;
    rst          = 1'b0;
    i_start_calc = 1'b0;
    taps         = '0;

    // Reset: held low three cycles, then released.
    idle_cycles(3);
    check("reset_wavelet", {24'h0, o_wavelet}, 32'h0);
    check("reset_valid", {31'h0, o_valid}, 32'h0);
    rst = 1'b1;
    idle_cycles(5);
    check("idle_state", {30'h0, dbg_state}, 32'h0);
    check("idle_no_valid", valid_cnt, 0);

    // Impulse on centre tap: 100*124 = 12400, >>>8 = 48.
    exp_q.push_back(8'h30);
    pulse_start(impulse(8'd100));
    wait_result("impulse", 0);

    // All taps 127: 127*(-30) = -3810, floor(/256) = -15.
    exp_q.push_back(8'hF1);
    pulse_start(fill(8'd127));
    wait_result("sum_127", 0);

    // All taps 1: -30 >>> 8 = -1.
    exp_q.push_back(8'hFF);
    pulse_start(fill(8'd1));
    wait_result("sum_1", 0);

    // Positive saturation: 127*180 + (-128)*(-210) = 49740 -> 194 -> 0x7F.
    exp_q.push_back(8'h7F);
    pulse_start(sign_pattern(8'd127, 8'h80));
    wait_result("sat_pos", 0);

    // Negative saturation: (-128)*180 + 127*(-210) = -49710 -> -195 -> 0x80.
    exp_q.push_back(8'h80);
    pulse_start(sign_pattern(8'h80, 8'd127));
    wait_result("sat_neg", 0);

    // Busy: second start three cycles after the first is ignored.
    valid_base = valid_cnt;
    exp_q.push_back(8'h30);
    pulse_start(impulse(8'd100));
    idle_cycles(2);
    pulse_start(fill(8'd127));
    wait_result("busy", 3);
    idle_cycles(15);
    check("busy_single_valid", valid_cnt - valid_base, 1);

    // Taps change mid-MAC: the captured all-ones window is still used.
    exp_q.push_back(8'hFF);
    pulse_start(fill(8'd1));
    idle_cycles(3);
    taps = impulse(8'd100);
    wait_result("tap_change", 3);

    // Abort: reset at cycle 5 clears the output and suppresses o_valid.
    valid_base = valid_cnt;
    pulse_start(fill(8'd127));
    idle_cycles(4);
    rst = 1'b0;
    #1;
    check("abort_wavelet", {24'h0, o_wavelet}, 32'h0);
    check("abort_valid", {31'h0, o_valid}, 32'h0);
    check("abort_state", {30'h0, dbg_state}, 32'h0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(15);
    check("abort_no_valid", valid_cnt - valid_base, 0);
    check("abort_hold", {24'h0, o_wavelet}, 32'h0);

    // Back-to-back: second start the cycle after o_valid.
    valid_base = valid_cnt;
    exp_q.push_back(8'h30);
    exp_q.push_back(8'hF1);
    pulse_start(impulse(8'd100));
    wait_result("b2b_first", 0);
    pulse_start(fill(8'd127));
    wait_result("b2b_second", 0);
    idle_cycles(5);
    check("b2b_valid_count", valid_cnt - valid_base, 2);
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
